// File: rtl/cpu_pkg.sv
// Shared CPU opcode map and register-usage decode.
// The pipeline hazard controller and the datapath Q5 dest-select both use these functions.
package cpu_pkg;

  localparam int CPU_OPC_W = 6;
  localparam int CPU_REG_W = 5;

  localparam logic [CPU_OPC_W-1:0] OPC_NOP   = 6'd0;
  localparam logic [CPU_OPC_W-1:0] OPC_ADD   = 6'd1;
  localparam logic [CPU_OPC_W-1:0] OPC_SUB   = 6'd2;
  localparam logic [CPU_OPC_W-1:0] OPC_LOAD  = 6'd4;
  localparam logic [CPU_OPC_W-1:0] OPC_MOVE  = 6'd5;
  localparam logic [CPU_OPC_W-1:0] OPC_MOVEI = 6'd16;
  localparam logic [CPU_OPC_W-1:0] OPC_SLI   = 6'd17;
  localparam logic [CPU_OPC_W-1:0] OPC_SRI   = 6'd18;
  localparam logic [CPU_OPC_W-1:0] OPC_ADDI  = 6'd19;
  localparam logic [CPU_OPC_W-1:0] OPC_SUBI  = 6'd20;
  localparam logic [CPU_OPC_W-1:0] OPC_BRA   = 6'd21;
  localparam logic [CPU_OPC_W-1:0] OPC_JMP   = 6'd22;

  // Immediate-style ops put their destination in the rs2 field.
  function automatic logic writes_rs2_dest(input logic [CPU_OPC_W-1:0] opc);
    return (opc == 6'd4) || (opc == 6'd5) || (opc >= 6'd15 && opc <= 6'd20);
  endfunction

  // Register-register ops write through the rd field.
  function automatic logic writes_rd_dest(input logic [CPU_OPC_W-1:0] opc);
    return (opc == 6'd1) || (opc == 6'd2) || (opc >= 6'd6 && opc <= 6'd14);
  endfunction

  function automatic logic reads_rs1(input logic [CPU_OPC_W-1:0] opc);
    return (opc >= 6'd1 && opc <= 6'd15) || (opc >= 6'd17 && opc <= 6'd21);
  endfunction

  function automatic logic reads_rs2(input logic [CPU_OPC_W-1:0] opc);
    return (opc == 6'd1) || (opc == 6'd2) || (opc >= 6'd6 && opc <= 6'd14);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// haz_scoreboard: three-slot (EX, DM, WB) record of in-flight register writes,
// shifted every cycle, with two read-port match compares against all valid slots.
module haz_scoreboard #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_vld,
  input  logic [REG_W-1:0] issue_dest,
  input  logic             rd1_en,
  input  logic [REG_W-1:0] rd1_reg,
  input  logic             rd2_en,
  input  logic [REG_W-1:0] rd2_reg,
  output logic             match
);

  logic             ex_vld_q, dm_vld_q, wb_vld_q;
  logic             ex_vld_d, dm_vld_d, wb_vld_d;
  logic [REG_W-1:0] ex_dst_q, dm_dst_q, wb_dst_q;
  logic [REG_W-1:0] ex_dst_d, dm_dst_d, wb_dst_d;

  // Slot shift: new issue enters EX, oldest entry falls out of WB.
  always_comb begin
    ex_vld_d = issue_vld;
    ex_dst_d = issue_dest;
    dm_vld_d = ex_vld_q;
    dm_dst_d = ex_dst_q;
    wb_vld_d = dm_vld_q;
    wb_dst_d = dm_dst_q;
    if (reset) begin
      ex_vld_d = 1'b0;
      dm_vld_d = 1'b0;
      wb_vld_d = 1'b0;
    end
  end

  // Slot registers.
  always_ff @(posedge clk) begin
    ex_vld_q <= ex_vld_d;
    dm_vld_q <= dm_vld_d;
    wb_vld_q <= wb_vld_d;
    ex_dst_q <= ex_dst_d;
    dm_dst_q <= dm_dst_d;
    wb_dst_q <= wb_dst_d;
  end

  // Any enabled read port hitting any valid slot; the register file has no write-before-read bypass.
  always_comb begin
    match = 1'b0;
    if (rd1_en && ((ex_vld_q && ex_dst_q == rd1_reg) ||
                   (dm_vld_q && dm_dst_q == rd1_reg) ||
                   (wb_vld_q && wb_dst_q == rd1_reg)))
      match = 1'b1;
    if (rd2_en && ((ex_vld_q && ex_dst_q == rd2_reg) ||
                   (dm_vld_q && dm_dst_q == rd2_reg) ||
                   (wb_vld_q && wb_dst_q == rd2_reg)))
      match = 1'b1;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: RAW-hazard stall and taken-branch squash control for the 5-stage pipeline.
// Optional macro PIPE_HAZ_PERF_EN adds saturating stall/flush performance counters.
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int OPC_W = 6,
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [OPC_W-1:0] id_opc,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             br_taken,
  output logic             stall,
  output logic             bubble,
`ifdef PIPE_HAZ_PERF_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic             kill_id
);

  logic             kill_id_q, kill_id_d;
  logic             live;
  logic             wr_rs2, wr_rd;
  logic             rd1_en, rd2_en;
  logic             match, hazard, redirect, issue_vld;
  logic [REG_W-1:0] issue_dest;

  // Decode of the ID instruction; a squashed slot is treated as a NOP.
  always_comb begin
    live       = id_valid && !kill_id_q;
    wr_rs2     = writes_rs2_dest(id_opc);
    wr_rd      = writes_rd_dest(id_opc);
    rd1_en     = live && reads_rs1(id_opc);
    rd2_en     = live && reads_rs2(id_opc);
    hazard     = live && match;
    issue_vld  = live && !hazard && (wr_rs2 || wr_rd);
    issue_dest = wr_rs2 ? id_rs2 : id_rd;
    redirect   = live && !hazard && br_taken && (id_opc == OPC_BRA || id_opc == OPC_JMP);
    kill_id_d  = reset ? 1'b0 : redirect;
  end

  haz_scoreboard #(.REG_W(REG_W)) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .issue_vld  (issue_vld),
    .issue_dest (issue_dest),
    .rd1_en     (rd1_en),
    .rd1_reg    (id_rs1),
    .rd2_en     (rd2_en),
    .rd2_reg    (id_rs2),
    .match      (match)
  );

  // One squashed ID cycle follows every redirect.
  always_ff @(posedge clk) begin
    kill_id_q <= kill_id_d;
  end

  assign stall   = hazard;
  assign bubble  = hazard || kill_id_q;
  assign kill_id = kill_id_q;

`ifdef PIPE_HAZ_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hazard && stall_cnt_q != {CNT_W{1'b1}})
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (redirect && flush_cnt_q != {CNT_W{1'b1}})
      flush_cnt_d = flush_cnt_q + 1'b1;
    if (reset) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. With PIPE_HAZ_PERF_EN defined the counters
// are built 2 bits wide so saturation is reached within the directed sequences.
module tb_pipe_hazard_ctrl;

  localparam int TB_CNT_W = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [5:0] id_opc;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       br_taken;
  logic       stall, bubble, kill_id;
`ifdef PIPE_HAZ_PERF_EN
  logic [TB_CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.OPC_W(6), .REG_W(5), .CNT_W(TB_CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .id_valid  (id_valid),
    .id_opc    (id_opc),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .id_rd     (id_rd),
    .br_taken  (br_taken),
    .stall     (stall),
    .bubble    (bubble),
`ifdef PIPE_HAZ_PERF_EN
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
`endif
    .kill_id   (kill_id)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] opc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic br);
    id_valid = v;
    id_opc   = opc;
    id_rs1   = rs1;
    id_rs2   = rs2;
    id_rd    = rd;
    br_taken = br;
  endtask

  task automatic expect_ctl(input string tag, input logic s, input logic b, input logic k);
    @(negedge clk);
    chk({tag, ".stall"},  32'(stall),   32'(s));
    chk({tag, ".bubble"}, 32'(bubble),  32'(b));
    chk({tag, ".kill"},   32'(kill_id), 32'(k));
  endtask

  task automatic drain();
    drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (2) tick();
    reset = 1'b0;
    expect_ctl("rst", 1'b0, 1'b0, 1'b0);
`ifdef PIPE_HAZ_PERF_EN
    chk("rst.stall_cnt", 32'(stall_cnt), 0);
    chk("rst.flush_cnt", 32'(flush_cnt), 0);
`endif
    tick();

    // 1: ADD r3<-r1,r2 then SUB r4<-r3,r5: three stall cycles, SUB issues on the fourth.
    drive(1'b1, 6'd1, 5'd1, 5'd2, 5'd3, 1'b0);
    expect_ctl("t1.add", 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 6'd2, 5'd3, 5'd5, 5'd4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      expect_ctl($sformatf("t1.sub_stall%0d", i), 1'b1, 1'b1, 1'b0);
      tick();
    end
    expect_ctl("t1.sub_issue", 1'b0, 1'b0, 1'b0);
    tick();
`ifdef PIPE_HAZ_PERF_EN
    chk("t1.stall_cnt", 32'(stall_cnt), 3);
`endif
    drain();

    // 2: ADDI dest r7 (rs2 field), two NOPs, ADD reading r7 via rs1: one stall cycle.
    drive(1'b1, 6'd19, 5'd1, 5'd7, 5'd0, 1'b0);
    expect_ctl("t2.addi", 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 6'd0, 5'd7, 5'd7, 5'd7, 1'b0);
    expect_ctl("t2.nop1", 1'b0, 1'b0, 1'b0);
    tick();
    expect_ctl("t2.nop2", 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 6'd1, 5'd7, 5'd8, 5'd9, 1'b0);
    expect_ctl("t2.add_stall", 1'b1, 1'b1, 1'b0);
    tick();
    expect_ctl("t2.add_issue", 1'b0, 1'b0, 1'b0);
    tick();
`ifdef PIPE_HAZ_PERF_EN
    chk("t2.stall_cnt_sat", 32'(stall_cnt), 3);
`endif
    drain();

    // 3: ADD r12, JMP taken, wrong-path SUB reading r12 is squashed without stalling.
    drive(1'b1, 6'd1, 5'd1, 5'd2, 5'd12, 1'b0);
    expect_ctl("t3.add", 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 6'd22, 5'd0, 5'd0, 5'd0, 1'b1);
    expect_ctl("t3.jmp", 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 6'd2, 5'd12, 5'd12, 5'd10, 1'b1);
    expect_ctl("t3.killed", 1'b0, 1'b1, 1'b1);
    tick();
`ifdef PIPE_HAZ_PERF_EN
    chk("t3.flush_cnt", 32'(flush_cnt), 1);
`endif
    drive(1'b1, 6'd1, 5'd10, 5'd0, 5'd13, 1'b0);
    expect_ctl("t3.after", 1'b0, 1'b0, 1'b0);
    tick();
    drain();

    // 4: MOVEI r2 then BRA on r2 with br_taken held: branch waits three cycles, then redirects.
    drive(1'b1, 6'd16, 5'd0, 5'd2, 5'd0, 1'b0);
    expect_ctl("t4.movei", 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 6'd21, 5'd2, 5'd0, 5'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      expect_ctl($sformatf("t4.bra_stall%0d", i), 1'b1, 1'b1, 1'b0);
      tick();
    end
    expect_ctl("t4.bra_go", 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    expect_ctl("t4.killed", 1'b0, 1'b1, 1'b1);
    tick();
    expect_ctl("t4.after", 1'b0, 1'b0, 1'b0);
`ifdef PIPE_HAZ_PERF_EN
    chk("t4.flush_cnt", 32'(flush_cnt), 2);
    chk("t4.stall_cnt_sat", 32'(stall_cnt), 3);
`endif
    tick();
    drain();

    // 5: LOAD r6 in EX, reset with dependent ADD in ID: hazard drops after the edge.
    drive(1'b1, 6'd4, 5'd1, 5'd6, 5'd0, 1'b0);
    expect_ctl("t5.load", 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 6'd1, 5'd6, 5'd0, 5'd11, 1'b0);
    reset = 1'b1;
    expect_ctl("t5.pre_rst", 1'b1, 1'b1, 1'b0);
    tick();
    reset = 1'b0;
    expect_ctl("t5.post_rst", 1'b0, 1'b0, 1'b0);
`ifdef PIPE_HAZ_PERF_EN
    chk("t5.stall_cnt_clr", 32'(stall_cnt), 0);
    chk("t5.flush_cnt_clr", 32'(flush_cnt), 0);
`endif
    tick();
    // The ADD issued freely, so a reader of r11 must now stall.
    drive(1'b1, 6'd3, 5'd11, 5'd0, 5'd0, 1'b0);
    expect_ctl("t5.dep_r11", 1'b1, 1'b1, 1'b0);
    tick();
`ifdef PIPE_HAZ_PERF_EN
    chk("t5.stall_cnt", 32'(stall_cnt), 1);
`endif
    // Register 0 is tracked like any other register.
    drain();
    drive(1'b1, 6'd1, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    drive(1'b1, 6'd1, 5'd0, 5'd4, 5'd5, 1'b0);
    expect_ctl("t6.r0_dep", 1'b1, 1'b1, 1'b0);
    tick();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
